// File: rtl/dec_pkg.sv
// Purpose: shared sizes and the one-hot lookup table for the 3-to-8 decoder.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: IN_W (select width), OUT_W (one-hot width), ONEHOT_LUT (entry i = 1 << i).
package dec_pkg;

  localparam int IN_W  = 3;
  localparam int OUT_W = 1 << IN_W;

  // Packed table: index i selects the one-hot word with bit i set.
  localparam logic [7:0][OUT_W-1:0] ONEHOT_LUT = {
    8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

endpackage

// File: rtl/dec_3to8_comb.sv
// Purpose: combinational 3-to-8 one-hot decode, coded as a shift or as a case.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs continuously.
// Ports: in (binary select), en (active-high enable), dec (one-hot result, 0 when disabled).
module dec_3to8_comb
  import dec_pkg::*;
#(
  parameter string STYLE = "SHIFT"
) (
  input  logic [IN_W-1:0]  in,
  input  logic             en,
  output logic [OUT_W-1:0] dec
);

  if (STYLE == "SHIFT") begin : g_shift
    // Operand is full output width so in=7 lands on the MSB without truncation.
    always_comb begin
      dec = '0;
      if (en) dec = OUT_W'(1) << in;
    end
  end else begin : g_case
    always_comb begin
      dec = '0;
      if (en) begin
        case (in)
          3'd0:    dec = ONEHOT_LUT[0];
          3'd1:    dec = ONEHOT_LUT[1];
          3'd2:    dec = ONEHOT_LUT[2];
          3'd3:    dec = ONEHOT_LUT[3];
          3'd4:    dec = ONEHOT_LUT[4];
          3'd5:    dec = ONEHOT_LUT[5];
          3'd6:    dec = ONEHOT_LUT[6];
          3'd7:    dec = ONEHOT_LUT[7];
          // Only reachable on an unknown select; decode to nothing.
          default: dec = '0;
        endcase
      end
    end
  end

endmodule

// File: rtl/dec_3to8.sv
// Purpose: 3-to-8 one-hot decoder built two ways (shift, case) with a registered cross-check.
// Latency: 1 cycle when REG_OUT=1, 0 cycles when REG_OUT=0; mismatch always 1 cycle.
// Backpressure: none; a new select is accepted every cycle.
// Ports: clk, rst_n (async active-low), in (select), en (enable),
//        out1 (shift result), out2 (case result), mismatch (out1 != out2, registered).
module dec_3to8 #(
  parameter int IN_W    = 3,
  parameter int OUT_W   = 8,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in,
  input  logic             en,
  output logic [OUT_W-1:0] out1,
  output logic [OUT_W-1:0] out2,
  output logic             mismatch
);

  logic [OUT_W-1:0] d1;
  logic [OUT_W-1:0] d2;

  dec_3to8_comb #(.STYLE("SHIFT")) u_shift (
    .in  (in),
    .en  (en),
    .dec (d1)
  );

  dec_3to8_comb #(.STYLE("CASE")) u_case (
    .in  (in),
    .en  (en),
    .dec (d2)
  );

  // The compare uses the pre-register decodes so the flag lines up with the
  // outputs it describes when REG_OUT=1; it clears on the next agreeing cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mismatch <= 1'b0;
    else        mismatch <= (d1 != d2);
  end

  if (REG_OUT) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out1 <= '0;
        out2 <= '0;
      end else begin
        out1 <= d1;
        out2 <= d2;
      end
    end
  end else begin : g_comb
    // Bypass: reset no longer touches the outputs, only the mismatch flag.
    assign out1 = d1;
    assign out2 = d2;
  end

`ifndef SYNTHESIS
  always @(negedge clk) begin
    if (rst_n) assert (out1 == out2);
  end
`endif

endmodule

// File: tb/tb_dec_3to8.sv
module tb_dec_3to8;

  logic       clk;
  logic       rst_n;
  logic [2:0] in;
  logic       en;
  logic [7:0] out1;
  logic [7:0] out2;
  logic       mismatch;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] sb_q[$];

  logic [7:0] exp_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  dec_3to8 #(.IN_W(3), .OUT_W(8), .REG_OUT(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .en       (en),
    .out1     (out1),
    .out2     (out2),
    .mismatch (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drive on the falling edge; the expected result is due after the next rising edge.
  task automatic apply(input logic e, input logic [2:0] s, input logic [7:0] exp);
    @(negedge clk);
    en = e;
    in = s;
    sb_q.push_back(exp);
  endtask

  // Monitor: each rising edge with an outstanding expectation is checked 1 time unit later.
  initial begin
    logic [7:0] exp;
    forever begin
      @(posedge clk);
      if (sb_q.size() > 0) begin
        #1;
        exp = sb_q.pop_front();
        chk("sb_out1", out1, exp);
        chk("sb_out2", out2, exp);
        chk("sb_mismatch", mismatch, 0);
        chk("sb_popcount", $countones(out1), $countones(exp));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    in    = 3'd5;

    // Reset held with an active decode on the inputs: outputs stay clear.
    #1;
    chk("rst_out1_pre", out1, 8'h00);
    chk("rst_out2_pre", out2, 8'h00);
    chk("rst_mismatch_pre", mismatch, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_out1", out1, 8'h00);
      chk("rst_out2", out2, 8'h00);
      chk("rst_mismatch", mismatch, 0);
    end

    // Disabled sweep, each select held 50 time units (5 cycles).
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 8; s++)
      repeat (5) apply(1'b0, 3'(s), 8'h00);

    // Enabled sweep against the hand-written table.
    for (int s = 0; s < 8; s++)
      apply(1'b1, 3'(s), exp_tab[s]);

    // Latency: step {en,in} 0000 -> 1111 and look either side of the edge.
    apply(1'b0, 3'd0, 8'h00);
    apply(1'b0, 3'd0, 8'h00);
    @(negedge clk);
    en = 1'b1;
    in = 3'd7;
    sb_q.push_back(8'h80);
    #1;
    chk("lat_pre_out1", out1, 8'h00);
    chk("lat_pre_out2", out2, 8'h00);
    @(posedge clk);
    #2;
    chk("lat_post_out1", out1, 8'h80);
    chk("lat_post_out2", out2, 8'h80);

    // Asynchronous reset between edges while the outputs hold 8'h80.
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out1", out1, 8'h00);
    chk("arst_out2", out2, 8'h00);
    chk("arst_mismatch", mismatch, 0);
    @(negedge clk);
    chk("arst_hold_out1", out1, 8'h00);
    // First edge after release loads the decode already on the inputs.
    rst_n = 1'b1;
    sb_q.push_back(8'h80);

    // Exhaustive {en,in} against the reference en ? 1<<in : 0.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      logic [7:0] m;
      v = 4'(i);
      m = v[3] ? (8'h01 << v[2:0]) : 8'h00;
      apply(v[3], v[2:0], m);
    end

    // Drain with a bounded wait.
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    #3;
    chk("sb_drain", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
